mac_seq: RTL and testbench

Dot-product sequencer that owns one free-running `mac` accumulator instance. On `start` it streams `len` operand pairs from two synchronous-read operand memories into the MAC and waits for the pipeline to drain. It returns the dot product with a one-cycle `done` pulse. The `mac` has no clear or enable, so the block gates operands to zero while idle and computes each result as the accumulator delta since `start`.

---
 rtl/mac_seq_pkg.sv | 15 +
 rtl/mac_seq_mac.sv | 34 +++
 rtl/mac_seq.sv | 129 ++++++++++++
 tb/tb_mac_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding and timing constants for mac_seq
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    localparam int DRAIN_CYCLES = 2;
    // Read-to-accumulate path: one cycle of memory read, one of operand register.
    localparam int MAC_LATENCY  = 2;

endpackage

// File: rtl/mac_seq_mac.sv
// rtl/mac_seq_mac.sv - free-running multiply-accumulator with registered operands
module mac #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      a_reset,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic [2*DATA_WIDTH-1:0]   result
);

    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;

    // Products and the running sum wrap silently at 2*DATA_WIDTH bits.
    always_comb begin
        acc_d = acc_q + ((2*DATA_WIDTH)'(a_q) * (2*DATA_WIDTH)'(b_q));
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - dot-product sequencer driving a clearless accumulator
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                      clk,
    input  logic                      a_reset,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic [ADDR_WIDTH-1:0]     a_base,
    input  logic [ADDR_WIDTH-1:0]     b_base,
    output logic [ADDR_WIDTH-1:0]     a_addr,
    output logic [ADDR_WIDTH-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0]     a_rdata,
    input  logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   dot_result
);

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    idx_q, idx_d;
    logic [1:0]              drain_q, drain_d;
    logic [ADDR_WIDTH-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [2*DATA_WIDTH-1:0] base_acc_q, base_acc_d;
    logic [2*DATA_WIDTH-1:0] dot_result_q, dot_result_d;
    logic                    done_q, done_d;
    logic                    fetch_valid_q;
    logic [DATA_WIDTH-1:0]   mac_a, mac_b;
    logic [2*DATA_WIDTH-1:0] mac_result;

    // Zero operands outside the fetch window keep the accumulator quiescent.
    assign mac_a = fetch_valid_q ? a_rdata : '0;
    assign mac_b = fetch_valid_q ? b_rdata : '0;

    mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
        .clk     (clk),
        .a_reset (a_reset),
        .a       (mac_a),
        .b       (mac_b),
        .result  (mac_result)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        base_acc_d   = base_acc_q;
        dot_result_d = dot_result_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = len;
                    idx_d      = '0;
                    drain_d    = '0;
                    base_acc_d = mac_result;
                    if (len != '0) begin
                        state_d  = FETCH;
                        a_addr_d = a_base;
                        b_addr_d = b_base;
                    end else begin
                        state_d  = DRAIN;
                    end
                end
            end
            FETCH: begin
                if (idx_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d    = idx_q + LEN_WIDTH'(1);
                    a_addr_d = a_addr_q + ADDR_WIDTH'(1);
                    b_addr_d = b_addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = CAPTURE;
                else                                  drain_d = drain_q + 2'd1;
            end
            CAPTURE: begin
                // Accumulator delta since start is this run's dot product.
                dot_result_d = mac_result - base_acc_q;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            drain_q       <= '0;
            a_addr_q      <= '0;
            b_addr_q      <= '0;
            base_acc_q    <= '0;
            dot_result_q  <= '0;
            done_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            drain_q       <= drain_d;
            a_addr_q      <= a_addr_d;
            b_addr_q      <= b_addr_d;
            base_acc_q    <= base_acc_d;
            dot_result_q  <= dot_result_d;
            done_q        <= done_d;
            fetch_valid_q <= (state_q == FETCH);
        end
    end

    assign a_addr     = a_addr_q;
    assign b_addr     = b_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign dot_result = dot_result_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed self-checking bench for mac_seq
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        a_reset;
    logic        start;
    logic [6:0]  len;
    logic [5:0]  a_base, b_base;
    logic [5:0]  a_addr, b_addr;
    logic [7:0]  a_rdata, b_rdata;
    logic        busy, done;
    logic [15:0] dot_result;

    logic [7:0]  mem_a [0:63];
    logic [7:0]  mem_b [0:63];
    logic [5:0]  addr_log [0:15];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cyc;
    int busy_err;
    int addr_moved;

    always #5 clk = ~clk;

    mac_seq dut (
        .clk        (clk),
        .a_reset    (a_reset),
        .start      (start),
        .len        (len),
        .a_base     (a_base),
        .b_base     (b_base),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .busy       (busy),
        .done       (done),
        .dot_result (dot_result)
    );

    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr];
        b_rdata <= mem_b[b_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues start in the current cycle (cycle 0), runs until done or budget.
    task automatic run(input logic [6:0] l, input logic [5:0] ab, input logic [5:0] bb,
                       input int busy_start_cyc);
        logic [5:0] addr0;
        int cyc;
        addr0      = a_addr;
        len        = l;
        a_base     = ab;
        b_base     = bb;
        start      = 1'b1;
        cyc        = 0;
        done_cyc   = -1;
        busy_err   = 0;
        addr_moved = 0;
        while (done_cyc < 0 && cyc < int'(l) + 20) begin
            step();
            cyc++;
            start = (cyc == busy_start_cyc);
            if (cyc >= 1 && cyc <= int'(l) && cyc <= 16) addr_log[cyc-1] = a_addr;
            if (a_addr != addr0) addr_moved = 1;
            if (busy !== (cyc <= int'(l) + 3)) busy_err++;
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
    endtask

    task automatic count_extra_done(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (done) cnt++;
        end
    endtask

    initial begin
        int extra;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3;
        mem_b[0] = 8'd4; mem_b[1] = 8'd5; mem_b[2] = 8'd6;
        mem_a[10] = 8'd255; mem_a[11] = 8'd255;
        mem_b[10] = 8'd255; mem_b[11] = 8'd255;
        mem_a[62] = 8'd2; mem_a[63] = 8'd3;
        mem_b[62] = 8'd1; mem_b[63] = 8'd1;

        a_reset = 1'b1;
        start   = 1'b0;
        len     = '0;
        a_base  = '0;
        b_base  = '0;
        step();
        step();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_addr", {a_addr, b_addr}, 0);
        check("reset_result", dot_result, 0);
        a_reset = 1'b0;
        step();

        // Basic run: 1*4 + 2*5 + 3*6
        run(7'd3, 6'd0, 6'd0, 0);
        check("basic_latency", done_cyc, 7);
        check("basic_result", dot_result, 32);
        check("basic_busy", busy_err, 0);
        check("basic_addr", {addr_log[0], addr_log[1], addr_log[2]}, {6'd0, 6'd1, 6'd2});
        step();
        check("done_pulse_width", done, 0);
        check("result_held", dot_result, 32);

        // Zero length: no address activity, result 0 after 4 cycles
        run(7'd0, 6'd20, 6'd20, 0);
        check("zero_latency", done_cyc, 4);
        check("zero_result", dot_result, 0);
        check("zero_addr_moved", addr_moved, 0);
        check("zero_busy", busy_err, 0);
        step();

        // Back-to-back: second start lands in the done cycle of the first
        run(7'd2, 6'd10, 6'd10, 0);
        check("b2b1_latency", done_cyc, 6);
        check("b2b1_result", dot_result, 64514);
        run(7'd3, 6'd0, 6'd0, 0);
        check("b2b2_latency", done_cyc, 7);
        check("b2b2_result", dot_result, 32);
        step();

        // Address wrap with an ignored start while busy: 2*1 + 3*1 + 1*4
        run(7'd3, 6'd62, 6'd62, 2);
        check("wrap_latency", done_cyc, 7);
        check("wrap_result", dot_result, 9);
        check("wrap_a_addr", {addr_log[0], addr_log[1], addr_log[2]}, {6'd62, 6'd63, 6'd0});
        check("wrap_busy", busy_err, 0);
        count_extra_done(12, extra);
        check("wrap_single_done", extra, 0);

        // Reset in cycle 2 of a len=5 run
        len    = 7'd5;
        a_base = 6'd0;
        b_base = 6'd0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        a_reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", {a_addr, b_addr}, 0);
        check("abort_result", dot_result, 0);
        step();
        a_reset = 1'b0;
        count_extra_done(10, extra);
        check("abort_no_done", extra, 0);

        run(7'd3, 6'd0, 6'd0, 0);
        check("post_reset_latency", done_cyc, 7);
        check("post_reset_result", dot_result, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
